// File: rtl/frame_pixel_fetcher.sv
// frame_pixel_fetcher: turns tracker (x_pos, y_pos) into reads of a double-buffered
// 1-bpp frame memory, upscales by 2^SCALE_SHIFT and owns display-bank swapping.
//
// Ports:
//   CLK_40, reset        system clock, synchronous active-high reset
//   clk_en_i             pixel-rate enable; pipeline advances only when high
//   count_en_i           active-video qualifier
//   x_pos_i, y_pos_i     tracker position
//   hsync_i, vsync_i     syncs aligned with position
//   frame_ready_i        one-cycle pulse: back bank fully written
//   mem_rd_en_o          read strobe, issued combinationally in the requesting beat
//   mem_addr_o           {display_bank, word index}; holds between reads
//   mem_rdata_i          read data, valid MEM_LATENCY beats after the strobe
//   pixel_o              upscaled pixel
//   pixel_valid_o        delayed count_en_i
//   hsync_o, vsync_o     delayed syncs
//   display_bank_o       bank currently scanned
//   frame_taken_o        one-cycle pulse on bank swap
module frame_pixel_fetcher #(
    parameter int X_LINE_WIDTH = 640,
    parameter int Y_LINE_WIDTH = 480,
    parameter int X_DATA_WIDTH = $clog2(X_LINE_WIDTH),
    parameter int Y_DATA_WIDTH = $clog2(Y_LINE_WIDTH),
    parameter int SCALE_SHIFT  = 2,
    parameter int WORD_BITS    = 16,
    parameter int MEM_LATENCY  = 2,
    parameter int ADDR_WIDTH   = 12
) (
    input  logic                    CLK_40,
    input  logic                    reset,
    input  logic                    clk_en_i,
    input  logic                    count_en_i,
    input  logic [X_DATA_WIDTH-1:0] x_pos_i,
    input  logic [Y_DATA_WIDTH-1:0] y_pos_i,
    input  logic                    hsync_i,
    input  logic                    vsync_i,
    input  logic                    frame_ready_i,
    output logic                    mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    input  logic [WORD_BITS-1:0]    mem_rdata_i,
    output logic                    pixel_o,
    output logic                    pixel_valid_o,
    output logic                    hsync_o,
    output logic                    vsync_o,
    output logic                    display_bank_o,
    output logic                    frame_taken_o
);
    localparam int IW  = ADDR_WIDTH - 1;
    localparam int WPL = (X_LINE_WIDTH >> SCALE_SHIFT) / WORD_BITS;
    localparam int BW  = $clog2(WORD_BITS);
    // log2 of output pixels covered by one memory word
    localparam int SW  = SCALE_SHIFT + BW;
    localparam logic [BW-1:0] MSB = BW'(WORD_BITS - 1);

    logic [IW-1:0]          word_idx;
    logic                   aligned, eof, take;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [MEM_LATENCY-1:0] rdv_q, rdv_d, act_q, act_d, hs_q, hs_d, vs_q, vs_d;
    logic [BW-1:0]          bit_q [MEM_LATENCY];
    logic [BW-1:0]          bit_d [MEM_LATENCY];
    logic [WORD_BITS-1:0]   word_q, word_d, word_src;
    logic                   pix_q, pix_d, pv_q, pv_d, hso_q, hso_d, vso_q, vso_d;
    logic                   bank_q, bank_d, taken_q, taken_d, pend_q, pend_d;

    assign pixel_o        = pix_q;
    assign pixel_valid_o  = pv_q;
    assign hsync_o        = hso_q;
    assign vsync_o        = vso_q;
    assign display_bank_o = bank_q;
    assign frame_taken_o  = taken_q;

    always_comb begin
        word_idx    = IW'(y_pos_i >> SCALE_SHIFT) * IW'(WPL) + IW'(x_pos_i >> SW);
        aligned     = x_pos_i[SW-1:0] == '0;
        eof         = clk_en_i & count_en_i & (x_pos_i == X_DATA_WIDTH'(X_LINE_WIDTH - 1))
                      & (y_pos_i == Y_DATA_WIDTH'(Y_LINE_WIDTH - 1));
        // a frame_ready landing on the end-of-frame beat still swaps this frame
        take        = eof & (pend_q | frame_ready_i);
        mem_rd_en_o = clk_en_i & count_en_i & aligned & ~reset;
        mem_addr_o  = reset ? '0 : mem_rd_en_o ? {bank_q, word_idx} : addr_q;
        addr_d      = mem_addr_o;
        // the returning word is used directly in the beat it arrives
        word_src    = rdv_q[MEM_LATENCY-1] ? mem_rdata_i : word_q;
        rdv_d       = rdv_q;
        act_d       = act_q;
        hs_d        = hs_q;
        vs_d        = vs_q;
        bit_d       = bit_q;
        word_d      = word_q;
        pix_d       = pix_q;
        pv_d        = pv_q;
        hso_d       = hso_q;
        vso_d       = vso_q;
        if (clk_en_i) begin
            rdv_d[0] = mem_rd_en_o;
            act_d[0] = count_en_i;
            hs_d[0]  = hsync_i;
            vs_d[0]  = vsync_i;
            bit_d[0] = x_pos_i[SCALE_SHIFT +: BW];
            for (int i = 1; i < MEM_LATENCY; i++) begin
                rdv_d[i] = rdv_q[i-1];
                act_d[i] = act_q[i-1];
                hs_d[i]  = hs_q[i-1];
                vs_d[i]  = vs_q[i-1];
                bit_d[i] = bit_q[i-1];
            end
            word_d = word_src;
            pix_d  = act_q[MEM_LATENCY-1] & word_src[MSB - bit_q[MEM_LATENCY-1]];
            pv_d   = act_q[MEM_LATENCY-1];
            hso_d  = hs_q[MEM_LATENCY-1];
            vso_d  = vs_q[MEM_LATENCY-1];
        end
        // bank control runs at CLK_40 rate so a ready pulse is never missed
        pend_d  = ~take & (pend_q | frame_ready_i);
        bank_d  = bank_q ^ take;
        taken_d = take;
    end

    always_ff @(posedge CLK_40) begin
        if (reset) begin
            addr_q  <= '0;
            rdv_q   <= '0;
            act_q   <= '0;
            hs_q    <= '0;
            vs_q    <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) bit_q[i] <= '0;
            word_q  <= '0;
            pix_q   <= 1'b0;
            pv_q    <= 1'b0;
            hso_q   <= 1'b0;
            vso_q   <= 1'b0;
            bank_q  <= 1'b0;
            taken_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            rdv_q   <= rdv_d;
            act_q   <= act_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            pix_q   <= pix_d;
            pv_q    <= pv_d;
            hso_q   <= hso_d;
            vso_q   <= vso_d;
            bank_q  <= bank_d;
            taken_q <= taken_d;
            pend_q  <= pend_d;
        end
    end
endmodule

// File: tb/tb_frame_pixel_fetcher.sv
// tb_frame_pixel_fetcher: directed scoreboard bench for frame_pixel_fetcher
module tb_frame_pixel_fetcher;
    logic        CLK_40 = 1'b0, reset = 1'b1, clk_en = 1'b0, count_en = 1'b0;
    logic        hs = 1'b0, vs = 1'b0, fr = 1'b0;
    logic [9:0]  x = '0;
    logic [8:0]  y = '0;
    logic        mem_rd_en, pixel_out, pixel_valid, hsync_out, vsync_out, display_bank, frame_taken;
    logic [11:0] mem_addr;
    logic [15:0] mem_rdata = '0, r1 = '0;
    logic [3:0]  q[$];
    int          tests = 0, fails = 0;
    logic        bank_m, pend_m;
    logic [11:0] addr_m;
    logic [15:0] word_m;
    bit          gap = 0;

    always #5 CLK_40 = ~CLK_40;

    frame_pixel_fetcher dut (
        .CLK_40(CLK_40), .reset(reset), .clk_en_i(clk_en), .count_en_i(count_en),
        .x_pos_i(x), .y_pos_i(y), .hsync_i(hs), .vsync_i(vs), .frame_ready_i(fr),
        .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
        .pixel_o(pixel_out), .pixel_valid_o(pixel_valid), .hsync_o(hsync_out),
        .vsync_o(vsync_out), .display_bank_o(display_bank), .frame_taken_o(frame_taken)
    );

    function automatic logic [15:0] memf(logic [11:0] a);
        logic [15:0] m;
        m = 16'(a) * 16'h9E37;
        return a == 0 ? 16'h8000 : (m ^ 16'h5A5A) | 16'h8000;
    endfunction

    // two-beat synchronous memory, clock-enabled by clk_en
    always @(posedge CLK_40) begin
        if (clk_en) begin
            if (mem_rd_en) r1 <= memf(mem_addr);
            mem_rdata <= r1;
        end
    end

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(int n);
        reset = 1; clk_en = 1; count_en = 1; x = 0; y = 0; fr = 0; hs = 0; vs = 0;
        #1;
        chk("rst_rd_en_comb", 16'(mem_rd_en), 0);
        chk("rst_addr_comb", 16'(mem_addr), 0);
        repeat (n) @(posedge CLK_40);
        #1;
        chk("rst_rd_en", 16'(mem_rd_en), 0);
        chk("rst_addr", 16'(mem_addr), 0);
        chk("rst_outs", 16'({pixel_out, pixel_valid, hsync_out, vsync_out}), 0);
        chk("rst_bank", 16'(display_bank), 0);
        chk("rst_taken", 16'(frame_taken), 0);
        reset = 0; count_en = 0;
        q.delete(); q.push_back('0); q.push_back('0);
        bank_m = 0; pend_m = 0; addr_m = '0; word_m = '0;
    endtask

    task automatic beat(int xi, int yi, bit ce, bit h = 0, bit v = 0, bit f = 0);
        logic [3:0]  prev, r;
        logic [10:0] idx;
        bit          rd, sw;
        if (gap) begin
            prev = {pixel_out, pixel_valid, hsync_out, vsync_out};
            clk_en = 0; count_en = ce; x = 10'(xi); y = 9'(yi);
            #1;
            chk("gap_rd_en", 16'(mem_rd_en), 0);
            @(posedge CLK_40); #1;
            chk("gap_hold", 16'({pixel_out, pixel_valid, hsync_out, vsync_out}), 16'(prev));
            chk("gap_taken", 16'(frame_taken), 0);
        end
        clk_en = 1; count_en = ce; x = 10'(xi); y = 9'(yi); hs = h; vs = v; fr = f;
        rd  = ce && (xi % 64 == 0);
        idx = 11'((yi >> 2) * 10 + (xi >> 6));
        if (rd) begin
            addr_m = {bank_m, idx};
            word_m = memf(addr_m);
        end
        r = {ce & word_m[15 - ((xi >> 2) % 16)], ce, h, v};
        q.push_back(r);
        sw = ce && xi == 639 && yi == 479 && (pend_m || f);
        pend_m = !sw && (pend_m || f);
        #1;
        chk("rd_en", 16'(mem_rd_en), 16'(rd));
        chk("addr", 16'(mem_addr), 16'(addr_m));
        @(posedge CLK_40); #1;
        fr = 0;
        if (sw) bank_m = !bank_m;
        chk("taken", 16'(frame_taken), 16'(sw));
        chk("bank", 16'(display_bank), 16'(bank_m));
        r = q.pop_front();
        chk("out{pix,pv,hs,vs}", 16'({pixel_out, pixel_valid, hsync_out, vsync_out}), 16'(r));
    endtask

    initial begin
        do_reset(3);
        beat(0, 0, 0); beat(0, 0, 0);
        for (int i = 0; i < 68; i++) beat(i, 0, 1, i % 7 == 0);
        for (int j = 4; j < 8; j++)
            for (int i = 60; i < 71; i++) beat(i, j, 1, 0, j == 5);
        beat(10, 100, 1, 0, 0, 1);
        for (int i = 11; i < 14; i++) beat(i, 100, 1);
        for (int i = 636; i < 640; i++) beat(i, 479, 1, 0, 1);
        beat(0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) beat(i, 0, 1);
        beat(637, 479, 1); beat(638, 479, 1); beat(639, 479, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) beat(i, 0, 1);
        beat(5, 10, 1, 0, 0, 1); beat(5, 20, 1, 0, 0, 1);
        beat(639, 479, 1);
        beat(639, 479, 1);
        beat(0, 0, 1); beat(1, 0, 1);
        gap = 1;
        for (int i = 0; i < 71; i++) beat(i, 8, 1, i >= 66, 0);
        beat(639, 479, 1, 0, 0, 1);
        beat(0, 0, 1); beat(1, 0, 0);
        gap = 0;
        for (int i = 62; i < 65; i++) beat(i, 4, 1);
        do_reset(1);
        beat(65, 4, 1); beat(66, 4, 1);
        for (int i = 0; i < 5; i++) beat(i, 0, 1);
        beat(0, 0, 0); beat(0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
